// File: rtl/program_counter.sv
// Registered next-PC stage: pc_out <= PcIn + (PcSrc ? ImmExt : PC_STEP), modulo 2^DATA_WIDTH.
// Latency: one core clock from input sample to pc_out; async active-low reset to RESET_VECTOR.
// Backpressure: none, the stage updates unconditionally on every rising edge out of reset.
module program_counter #(
  parameter int                       DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]    RESET_VECTOR = '0,
  parameter int                       PC_STEP      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] PcIn,
  input  logic                  PcSrc,
  input  logic [DATA_WIDTH-1:0] ImmExt,
  output logic [DATA_WIDTH-1:0] pc_out
);

  logic [DATA_WIDTH-1:0] pc_seq;
  logic [DATA_WIDTH-1:0] pc_tgt;
  logic [DATA_WIDTH-1:0] pc_nxt;

  // Plain modulo adds: carry is dropped, negative offsets walk the PC backward.
  always_comb begin
    pc_seq = PcIn + DATA_WIDTH'(PC_STEP);
    pc_tgt = PcIn + ImmExt;
    pc_nxt = PcSrc ? pc_tgt : pc_seq;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_out <= RESET_VECTOR;
    end else begin
      pc_out <= pc_nxt;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: reset, sequential/branch arithmetic, wrap, sampling, async reset.
module tb_program_counter;

  logic        clk;
  logic        reset;
  logic [31:0] PcIn;
  logic        PcSrc;
  logic [31:0] ImmExt;
  logic [31:0] pc_out;

  int checks   = 0;
  int failures = 0;

  program_counter dut (
    .clk    (clk),
    .reset  (reset),
    .PcIn   (PcIn),
    .PcSrc  (PcSrc),
    .ImmExt (ImmExt),
    .pc_out (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Drive a vector at the falling edge, then sample just after the next rising edge.
  task automatic step(input string tag, input logic [31:0] pc, input logic src,
                      input logic [31:0] imm, input logic [31:0] exp);
    @(negedge clk);
    PcIn   = pc;
    PcSrc  = src;
    ImmExt = imm;
    @(posedge clk);
    #1;
    chk(tag, pc_out, exp);
  endtask

  initial begin
    reset  = 1'b0;
    PcIn   = 32'h0000_1234;
    PcSrc  = 1'b1;
    ImmExt = 32'h0000_0055;
    #2;
    chk("reset_immediate", pc_out, 32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", pc_out, 32'h0000_0000);
    end

    // Release reset at a falling edge with the first vector already applied.
    @(negedge clk);
    PcIn   = 32'h0000_0000;
    PcSrc  = 1'b0;
    ImmExt = 32'h0000_0004;
    reset  = 1'b1;
    #1;
    chk("release_no_edge", pc_out, 32'h0000_0000);
    @(posedge clk);
    #1;
    chk("seq_first", pc_out, 32'h0000_0004);

    step("branch_fwd",    32'h0000_1000, 1'b1, 32'h0000_000C, 32'h0000_100C);
    step("branch_back",   32'h0000_0100, 1'b1, 32'hFFFF_FFF0, 32'h0000_00F0);
    step("seq_wrap",      32'hFFFF_FFFC, 1'b0, 32'h1234_5678, 32'h0000_0000);
    step("tgt_wrap",      32'hFFFF_FFF0, 1'b1, 32'h0000_0020, 32'h0000_0010);
    step("misaligned",    32'h0000_1001, 1'b1, 32'h0000_0002, 32'h0000_1003);
    step("seq_msb_carry", 32'h7FFF_FFFC, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000);
    step("imm_ignored",   32'h0000_0200, 1'b0, 32'hDEAD_BEEC, 32'h0000_0204);

    // Mid-cycle input changes must not disturb pc_out until the next edge.
    @(negedge clk);
    PcIn   = 32'h0000_0040;
    PcSrc  = 1'b0;
    ImmExt = 32'h0000_0100;
    #1;
    chk("sample_hold_a", pc_out, 32'h0000_0204);
    PcSrc = 1'b1;
    #1;
    chk("sample_hold_b", pc_out, 32'h0000_0204);
    ImmExt = 32'h0000_0200;
    #1;
    chk("sample_hold_c", pc_out, 32'h0000_0204);
    @(posedge clk);
    #1;
    chk("sample_edge", pc_out, 32'h0000_0240);

    // Asynchronous reset in the middle of a cycle.
    step("pre_async", 32'h0000_1000, 1'b1, 32'h0000_000C, 32'h0000_100C);
    #2;
    reset = 1'b0;
    #1;
    chk("async_assert", pc_out, 32'h0000_0000);
    @(posedge clk);
    #1;
    chk("async_edge_ignored", pc_out, 32'h0000_0000);
    @(negedge clk);
    PcIn   = 32'h0000_0020;
    PcSrc  = 1'b0;
    ImmExt = 32'h0000_0400;
    reset  = 1'b1;
    #1;
    chk("async_release", pc_out, 32'h0000_0000);
    @(posedge clk);
    #1;
    chk("async_first_edge", pc_out, 32'h0000_0024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Registered program-counter stage of the RISC-V core datapath.
- Each rising clock edge loads pc_out with the next instruction address computed from PcIn:
  - sequential: PcIn + 4
  - branch/jump: PcIn + ImmExt, selected by PcSrc
- Sits between the branch-decision logic and the instruction-memory address port.

Parameters:
- DATA_WIDTH, 32, address/data width of PcIn, ImmExt and pc_out.
- RESET_VECTOR, 32'h0000_0000, value loaded into pc_out while reset is asserted.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = asserted).
- PcIn  input  DATA_WIDTH  current PC value, the base for both next-PC candidates.
- PcSrc  input  1  next-PC select: 0 = PcIn + PC_STEP, 1 = PcIn + ImmExt.
- ImmExt  input  DATA_WIDTH  sign-extended branch/jump offset, two's complement.
- pc_out  output  DATA_WIDTH  registered next PC.

Behaviour:
- One clock, one register (pc_out). No other state.
- Reset:
  - reset=0 forces pc_out = RESET_VECTOR immediately, independent of clk.
  - pc_out holds that value while reset stays low.
  - On release (0->1), the first update happens at the next rising clk edge.
  - Reset asserted mid-operation overrides any pending update.
  - A rising edge coinciding with active reset is ignored.
- Next-PC arithmetic, combinational, DATA_WIDTH-bit modulo 2^DATA_WIDTH:
  - pc_seq = PcIn + PC_STEP
  - pc_tgt = PcIn + ImmExt
  - Carry out is discarded; wrap-around is silent (e.g. 0xFFFF_FFFC + 4 = 0).
  - Negative ImmExt (MSB=1) moves the PC backward by plain two's-complement addition.
  - No additional sign extension inside the block.
- Register update on rising clk edge with reset=1:
  - pc_out <= PcSrc ? pc_tgt : pc_seq.
- Latency: exactly one clock from input sample to pc_out.
  - Inputs sampled at the edge.
  - pc_out is stable for the whole following cycle.
  - Input changes between edges have no effect on pc_out.
- No alignment checking or masking: pc_out is the raw sum. Misaligned targets pass through unchanged.
- PcSrc = X/Z is not a supported input. The bench must drive all inputs to known values before releasing reset.
- pc_out drives no combinational path back to any input. The block is purely a registered output.

Test Plan:
- Reset: drive reset=0 with arbitrary inputs, no clock edge -> pc_out = 0x0000_0000 immediately; still 0 after several edges while reset=0.
- Sequential: reset=1, PcIn=0x0000_0000, PcSrc=0, ImmExt=0x0000_0004 -> pc_out = 0x0000_0004 after the next rising edge.
- Branch: PcIn=0x0000_1000, PcSrc=1, ImmExt=0x0000_000C -> pc_out = 0x0000_100C after one edge.
- Backward branch and wrap:
  - PcIn=0x0000_0100, PcSrc=1, ImmExt=0xFFFF_FFF0 -> pc_out = 0x0000_00F0.
  - PcIn=0xFFFF_FFFC, PcSrc=0 -> pc_out = 0x0000_0000.
- Sampling: change PcSrc/ImmExt mid-cycle (between edges) -> pc_out unchanged until the next edge, then reflects values present at that edge.
- Async reset mid-run: pc_out=0x0000_100C, pull reset low between edges -> pc_out = 0 within the same cycle. Release reset with PcIn=0x20, PcSrc=0 -> pc_out = 0x24 at the first edge after release.
